// File: rtl/traffic_phase_scheduler_if.sv
// Request and lamp-side signals of the crossroads phase scheduler.
//   veh_req     : country-road vehicle present (level)
//   ped_req     : pedestrian button (pulse)
//   led         : {MR,MY,MG,CR,CY,CG}
//   ped_walk    : walk lamp
//   bcd         : two-digit BCD countdown, tens in [7:4]
//   phase       : current state code, debug only
//   ped_pending : latched pedestrian request
// master drives the requests; slave is the scheduler.
interface traffic_phase_scheduler_if;
    logic       veh_req;
    logic       ped_req;
    logic [5:0] led;
    logic       ped_walk;
    logic [7:0] bcd;
    logic [2:0] phase;
    logic       ped_pending;

    modport master (
        output veh_req, ped_req,
        input  led, ped_walk, bcd, phase, ped_pending
    );

    modport slave (
        input  veh_req, ped_req,
        output led, ped_walk, bcd, phase, ped_pending
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Crossroads phase scheduler. Main road holds green by default; country-road vehicles and
// pedestrians are granted round-robin, each conflicting phase preceded by an all-red interval.
// Every output is a register or a decode of the state register.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus_io : request inputs and lamp/countdown outputs (slave side)
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned T_MG     = 60,
    parameter int unsigned T_Y      = 4,
    parameter int unsigned T_CG     = 20,
    parameter int unsigned T_PED    = 15,
    parameter int unsigned T_AR     = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    traffic_phase_scheduler_if.slave  bus_io
);

    typedef enum logic [2:0] {
        StMg  = 3'd0,
        StMy  = 3'd1,
        StAr  = 3'd2,
        StCg  = 3'd3,
        StCy  = 3'd4,
        StPed = 3'd5
    } state_e;

    function automatic logic [7:0] to_bcd(int unsigned v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    localparam int unsigned CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0]  BcdMg  = to_bcd(T_MG);
    localparam logic [7:0]  BcdY   = to_bcd(T_Y);
    localparam logic [7:0]  BcdCg  = to_bcd(T_CG);
    localparam logic [7:0]  BcdPed = to_bcd(T_PED);
    localparam logic [7:0]  BcdAr  = to_bcd(T_AR);

    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    state_e          state_q, state_d;
    state_e          dest_q, dest_d;
    logic [7:0]      bcd_q, bcd_d;
    logic            last_ped_q, last_ped_d;
    logic            ped_pending_q, ped_pending_d;

    logic            tick;
    logic            expire;
    logic [7:0]      bcd_dec;
    state_e          grant;

    assign tick   = (tick_cnt_q == CntW'(TICK_DIV - 1));
    assign expire = tick && (bcd_q == 8'h01);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);

    // BCD borrow: units 0 wraps to 9 and takes one from tens.
    assign bcd_dec = (bcd_q[3:0] == 4'd0) ? {bcd_q[7:4] - 4'd1, 4'd9}
                                          : {bcd_q[7:4], bcd_q[3:0] - 4'd1};

    // Contention goes to whoever was not served last; a request withdrawn during MY
    // falls back to main green.
    always_comb begin
        grant = StMg;
        if (ped_pending_q && bus_io.veh_req) begin
            grant = last_ped_q ? StCg : StPed;
        end else if (ped_pending_q) begin
            grant = StPed;
        end else if (bus_io.veh_req) begin
            grant = StCg;
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        last_ped_d = last_ped_q;
        bcd_d      = tick ? bcd_dec : bcd_q;
        case (state_q)
            StMg: begin
                if (expire) begin
                    if (bus_io.veh_req || ped_pending_q) begin
                        state_d = StMy;
                        bcd_d   = BcdY;
                    end else begin
                        bcd_d = BcdMg;
                    end
                end
            end
            StMy: begin
                if (expire) begin
                    state_d = StAr;
                    dest_d  = grant;
                    bcd_d   = BcdAr;
                end
            end
            StAr: begin
                if (expire) begin
                    state_d = dest_q;
                    case (dest_q)
                        StCg: begin
                            bcd_d      = BcdCg;
                            last_ped_d = 1'b0;
                        end
                        StPed: begin
                            bcd_d      = BcdPed;
                            last_ped_d = 1'b1;
                        end
                        default: bcd_d = BcdMg;
                    endcase
                end
            end
            StCg: begin
                // Gap-out: an empty approach ends country green early.
                if (expire || (tick && !bus_io.veh_req)) begin
                    state_d = StCy;
                    bcd_d   = BcdY;
                end
            end
            StCy, StPed: begin
                if (expire) begin
                    state_d = StAr;
                    dest_d  = StMg;
                    bcd_d   = BcdAr;
                end
            end
            default: begin
                state_d = StMg;
                bcd_d   = BcdMg;
            end
        endcase
    end

    // Entry into PED clears the latch and wins over a same-cycle button press.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_d == StPed && state_q != StPed) begin
            ped_pending_d = 1'b0;
        end else if (bus_io.ped_req && state_q != StPed) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            state_q       <= StMg;
            dest_q        <= StMg;
            bcd_q         <= BcdMg;
            last_ped_q    <= 1'b1;
            ped_pending_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            dest_q        <= dest_d;
            bcd_q         <= bcd_d;
            last_ped_q    <= last_ped_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        bus_io.ped_walk = 1'b0;
        case (state_q)
            StMy:    bus_io.led = 6'b010100;
            StAr:    bus_io.led = 6'b100100;
            StCg:    bus_io.led = 6'b100001;
            StCy:    bus_io.led = 6'b100010;
            StPed: begin
                bus_io.led      = 6'b100100;
                bus_io.ped_walk = 1'b1;
            end
            default: bus_io.led = 6'b001100;
        endcase
    end

    assign bus_io.bcd         = bcd_q;
    assign bus_io.phase       = state_q;
    assign bus_io.ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with TICK_DIV=4, T_MG=5, T_Y=2, T_CG=4,
// T_PED=3, T_AR=1. Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_phase_scheduler;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .TICK_DIV (4),
        .T_MG     (5),
        .T_Y      (2),
        .T_CG     (4),
        .T_PED    (3),
        .T_AR     (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] led_of(input int unsigned ph);
        case (ph)
            1:       return 6'b010100;
            2:       return 6'b100100;
            3:       return 6'b100001;
            4:       return 6'b100010;
            5:       return 6'b100100;
            default: return 6'b001100;
        endcase
    endfunction

    task automatic expect_state(input string tag, input int unsigned ph, input int unsigned b);
        check({tag, "_phase"}, bus.phase, ph);
        check({tag, "_led"}, bus.led, led_of(ph));
        check({tag, "_walk"}, bus.ped_walk, (ph == 5) ? 1 : 0);
        check({tag, "_bcd"}, bus.bcd, b);
    endtask

    // Each tick is four clk cycles; called from a falling edge, returns on one.
    task automatic ticks(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset with a button press in the first clk after release and veh_req held high;
    // returns on the falling edge right after the first tick.
    task automatic reset_with_both();
        bus.veh_req = 1'b1;
        bus.ped_req = 1'b1;
        do_reset();
        @(negedge clk);
        bus.ped_req = 1'b0;
        check("both_pend_set", bus.ped_pending, 1);
        repeat (3) @(negedge clk);
    endtask

    int unsigned s2_ph  [15] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 2, 0};
    int unsigned s2_bcd [15] = '{'h04, 'h03, 'h02, 'h01, 'h02, 'h01, 'h01, 'h04, 'h03,
                                 'h02, 'h01, 'h02, 'h01, 'h01, 'h05};
    int unsigned s1_bcd [5]  = '{'h03, 'h02, 'h01, 'h05, 'h04};

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.veh_req = 1'b0;
        bus.ped_req = 1'b0;
        @(negedge clk);

        // 1: idle main green
        do_reset();
        expect_state("s1_rst", 0, 'h05);
        check("s1_rst_pend", bus.ped_pending, 0);
        repeat (3) @(negedge clk);
        check("s1_pretick_bcd", bus.bcd, 'h05);
        @(negedge clk);
        expect_state("s1_t1", 0, 'h04);
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            expect_state($sformatf("s1_t%0d", i + 2), 0, s1_bcd[i]);
        end

        // 2: vehicle held, full country cycle
        bus.veh_req = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            ticks(1);
            expect_state($sformatf("s2_t%0d", i + 1), s2_ph[i], s2_bcd[i]);
        end

        // 3: glitch between ticks ignored, then gap-out
        bus.veh_req = 1'b1;
        do_reset();
        ticks(9);
        expect_state("s3_cg03", 3, 'h03);
        bus.veh_req = 1'b0;
        @(negedge clk);
        bus.veh_req = 1'b1;
        repeat (3) @(negedge clk);
        expect_state("s3_glitch", 3, 'h02);
        bus.veh_req = 1'b0;
        ticks(1);
        expect_state("s3_gapout", 4, 'h02);
        ticks(2);
        expect_state("s3_ar", 2, 'h01);
        ticks(1);
        expect_state("s3_mg", 0, 'h05);

        // 4: pedestrian only
        bus.veh_req = 1'b0;
        do_reset();
        ticks(1);
        bus.ped_req = 1'b1;
        check("s4_pend_before", bus.ped_pending, 0);
        @(negedge clk);
        bus.ped_req = 1'b0;
        check("s4_pend_after", bus.ped_pending, 1);
        repeat (3) @(negedge clk);
        expect_state("s4_t2", 0, 'h03);
        ticks(3);
        expect_state("s4_my", 1, 'h02);
        ticks(2);
        expect_state("s4_ar", 2, 'h01);
        bus.ped_req = 1'b1;
        ticks(1);
        expect_state("s4_ped", 5, 'h03);
        check("s4_pend_clr", bus.ped_pending, 0);
        @(negedge clk);
        check("s4_ped_ignored", bus.ped_pending, 0);
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        expect_state("s4_ped2", 5, 'h02);
        ticks(2);
        expect_state("s4_ar2", 2, 'h01);
        ticks(1);
        expect_state("s4_mg", 0, 'h05);

        // 5: round-robin under contention
        reset_with_both();
        ticks(6);
        expect_state("s5_ar1", 2, 'h01);
        ticks(1);
        expect_state("s5_g1_cg", 3, 'h04);
        check("s5_pend_cg", bus.ped_pending, 1);
        ticks(7);
        expect_state("s5_mg1", 0, 'h05);
        check("s5_pend_mg", bus.ped_pending, 1);
        ticks(7);
        expect_state("s5_ar2", 2, 'h01);
        ticks(1);
        expect_state("s5_g2_ped", 5, 'h03);
        check("s5_pend_clr", bus.ped_pending, 0);
        ticks(4);
        expect_state("s5_mg2", 0, 'h05);
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        check("s5_pend_again", bus.ped_pending, 1);
        ticks(6);
        expect_state("s5_ar3", 2, 'h01);
        ticks(1);
        expect_state("s5_g3_cg", 3, 'h04);

        // 6: asynchronous reset mid country green
        reset_with_both();
        ticks(8);
        expect_state("s6_cg03", 3, 'h03);
        check("s6_pend", bus.ped_pending, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("s6_async", 0, 'h05);
        check("s6_async_pend", bus.ped_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.veh_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
